nibble_uart_tx: RTL and testbench

//  Read-side consumer for the 4-bit async FIFO, in the read clock domain (clk = rclk).

---
 rtl/nibble_uart_tx_if.sv | 21 ++
 rtl/nibble_uart_tx.sv | 159 +++++++++++++++
 tb/tb_nibble_uart_tx.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_uart_tx_if.sv
// FIFO read-port bundle between the 4-bit async FIFO (slave) and its
// read-side consumer (master).
interface nibble_uart_tx_if #(
    parameter int DATA_WIDTH = 4
);
    logic                  empty;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rinc;

    modport master (
        input  empty,
        input  rdata,
        output rinc
    );

    modport slave (
        output empty,
        output rdata,
        input  rinc
    );
endinterface

// File: rtl/nibble_uart_tx.sv
// Pops nibble pairs from the read side of the async FIFO, packs them low-first
// into bytes and sends each byte as an 8N1 UART frame through a one-byte holding register.
module nibble_uart_tx #(
    parameter int DATA_WIDTH   = 4,
    parameter int CLKS_PER_BIT = 16,
    parameter int RD_LAT       = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    nibble_uart_tx_if.master        fifo,
    output logic                    tx,
    output logic                    busy,
    output logic                    half_pending
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int LW = $clog2(RD_LAT + 1);
    localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(RD_LAT - 1);

    localparam logic [0:0] F_IDLE  = 1'b0;
    localparam logic [0:0] F_WAIT  = 1'b1;

    localparam logic [1:0] T_IDLE  = 2'd0;
    localparam logic [1:0] T_START = 2'd1;
    localparam logic [1:0] T_DATA  = 2'd2;
    localparam logic [1:0] T_STOP  = 2'd3;

    logic [0:0]            f_state;
    logic [LW-1:0]         lat_cnt;
    logic [DATA_WIDTH-1:0] lo_nibble;
    logic                  hold_valid;
    logic [7:0]            hold_byte;

    logic [1:0]            t_state;
    logic [TW-1:0]         bit_timer;
    logic [2:0]            bit_idx;
    logic [7:0]            shift_reg;

    logic                  bit_end;
    logic                  capture;
    logic                  tx_load;

    assign bit_end = (bit_timer == BIT_LAST);
    assign capture = (f_state == F_WAIT) && (lat_cnt == LAT_LAST);
    assign tx_load = hold_valid &&
                     ((t_state == T_IDLE) || ((t_state == T_STOP) && bit_end));
    assign busy    = (t_state != T_IDLE);

    // Gated by rst_n so no pop can be requested while the block is held in reset.
    assign fifo.rinc = rst_n && en && !fifo.empty && !hold_valid && (f_state == F_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_state      <= F_IDLE;
            lat_cnt      <= '0;
            lo_nibble    <= '0;
            half_pending <= 1'b0;
            hold_valid   <= 1'b0;
            hold_byte    <= '0;
        end else begin
            if (f_state == F_IDLE) begin
                if (fifo.rinc) begin
                    f_state <= F_WAIT;
                    lat_cnt <= '0;
                end
            end else begin
                if (capture) begin
                    f_state <= F_IDLE;
                    lat_cnt <= '0;
                    if (!half_pending) begin
                        lo_nibble    <= fifo.rdata;
                        half_pending <= 1'b1;
                    end else begin
                        hold_byte    <= {fifo.rdata, lo_nibble};
                        hold_valid   <= 1'b1;
                        half_pending <= 1'b0;
                    end
                end else begin
                    lat_cnt <= lat_cnt + 1'b1;
                end
            end
            // A completing pair needs hold_valid=0 to have been popped, so this never races the set above.
            if (tx_load) begin
                hold_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_state   <= T_IDLE;
            bit_timer <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
        end else begin
            case (t_state)
                T_IDLE: begin
                    bit_timer <= '0;
                    bit_idx   <= '0;
                    if (tx_load) begin
                        shift_reg <= hold_byte;
                        tx        <= 1'b0;
                        t_state   <= T_START;
                    end
                end
                T_START: begin
                    if (bit_end) begin
                        bit_timer <= '0;
                        bit_idx   <= '0;
                        tx        <= shift_reg[0];
                        t_state   <= T_DATA;
                    end else begin
                        bit_timer <= bit_timer + 1'b1;
                    end
                end
                T_DATA: begin
                    if (bit_end) begin
                        bit_timer <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            tx      <= 1'b1;
                            t_state <= T_STOP;
                        end else begin
                            bit_idx   <= bit_idx + 1'b1;
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            tx        <= shift_reg[1];
                        end
                    end else begin
                        bit_timer <= bit_timer + 1'b1;
                    end
                end
                T_STOP: begin
                    if (bit_end) begin
                        bit_timer <= '0;
                        bit_idx   <= '0;
                        // A held byte starts its start bit straight out of the stop bit.
                        if (tx_load) begin
                            shift_reg <= hold_byte;
                            tx        <= 1'b0;
                            t_state   <= T_START;
                        end else begin
                            t_state   <= T_IDLE;
                        end
                    end else begin
                        bit_timer <= bit_timer + 1'b1;
                    end
                end
                default: begin
                    t_state <= T_IDLE;
                    tx      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_uart_tx.sv
// Directed bench for nibble_uart_tx: one instance with RD_LAT=1 and one with RD_LAT=2,
// each fed by a small behavioural FIFO model, frames decoded sample-by-sample.
module tb_nibble_uart_tx;

   localparam int CPB   = 4;
   localparam int LIMIT = 400;

   typedef struct {
      logic [3:0] lo;
      logic [3:0] hi;
      logic [7:0] expByte;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic en;
   logic tx, busy, half_pending;
   logic tx2, busy2, half_pending2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   nibble_uart_tx_if #(.DATA_WIDTH(4)) fifo_if ();
   nibble_uart_tx_if #(.DATA_WIDTH(4)) fifo2_if ();

   nibble_uart_tx #(.DATA_WIDTH(4), .CLKS_PER_BIT(CPB), .RD_LAT(1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .fifo         (fifo_if.master),
      .tx           (tx),
      .busy         (busy),
      .half_pending (half_pending)
   );

   nibble_uart_tx #(.DATA_WIDTH(4), .CLKS_PER_BIT(CPB), .RD_LAT(2)) dut2 (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .fifo         (fifo2_if.master),
      .tx           (tx2),
      .busy         (busy2),
      .half_pending (half_pending2)
   );

   // FIFO model for the RD_LAT=1 instance: popped word appears one edge after acceptance.
   logic [3:0] mem [0:63];
   logic [5:0] wrPtr = 6'd0;
   logic [5:0] rdPtr = 6'd0;
   assign fifo_if.empty = (wrPtr == rdPtr);
   always @(posedge clk) begin
      if (fifo_if.rinc) begin
         fifo_if.rdata <= mem[rdPtr];
         rdPtr         <= rdPtr + 6'd1;
      end
   end

   // FIFO model for the RD_LAT=2 instance: junk after the pop edge, real data only for the E0+2 capture.
   logic [3:0] mem2 [0:63];
   logic [5:0] wrPtr2 = 6'd0;
   logic [5:0] rdPtr2 = 6'd0;
   logic       s1Valid = 1'b0;
   logic [3:0] s1Data  = 4'h0;
   assign fifo2_if.empty = (wrPtr2 == rdPtr2);
   always @(posedge clk) begin
      s1Valid <= fifo2_if.rinc;
      if (fifo2_if.rinc) begin
         s1Data <= mem2[rdPtr2];
         rdPtr2 <= rdPtr2 + 6'd1;
      end
      fifo2_if.rdata <= s1Valid ? s1Data : (fifo2_if.rinc ? 4'h0 : 4'hF);
   end

   // Accepted pops and any back-to-back rinc cycles, sampled at the accepting edge.
   int   popCount = 0;
   int   rincDbl  = 0;
   logic rincPrev = 1'b0;
   int   frameStartPops = 0;
   always @(posedge clk) begin
      if (fifo_if.rinc) popCount <= popCount + 1;
      if (fifo_if.rinc && rincPrev) rincDbl <= rincDbl + 1;
      rincPrev <= fifo_if.rinc;
   end

   function automatic logic getTx(input int w);
      return (w == 0) ? tx : tx2;
   endfunction

   function automatic logic getBusy(input int w);
      return (w == 0) ? busy : busy2;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input int w, input logic [3:0] v);
      if (w == 0) begin
         mem[wrPtr] = v;
         wrPtr = wrPtr + 6'd1;
      end else begin
         mem2[wrPtr2] = v;
         wrPtr2 = wrPtr2 + 6'd1;
      end
   endtask

   // Called on a negedge; returns on the negedge one cycle after the stop bit ends.
   task automatic checkFrame(input int w, input logic [7:0] expByte, input bit backToBack,
                             input string name);
      int         waited;
      int         badBits;
      int         badBusy;
      logic [7:0] rx;
      logic [9:0] pattern;
      logic       s;
      pattern = {1'b1, expByte, 1'b0};
      waited  = 0;
      while (getTx(w) !== 1'b0 && waited < LIMIT) begin
         @(negedge clk);
         waited++;
      end
      checkOutput($sformatf("%s start", name), (waited < LIMIT) ? 32'd1 : 32'd0, 32'd1);
      if (waited >= LIMIT) return;
      frameStartPops = popCount;
      badBits = 0;
      badBusy = 0;
      rx      = 8'h00;
      for (int k = 0; k < 10 * CPB; k++) begin
         s = getTx(w);
         if (s !== pattern[k / CPB]) badBits++;
         if (getBusy(w) !== 1'b1) badBusy++;
         if ((k % CPB) == CPB / 2 && k >= CPB && k < 9 * CPB) rx[k / CPB - 1] = s;
         @(negedge clk);
      end
      checkOutput($sformatf("%s byte", name), {24'd0, rx}, {24'd0, expByte});
      checkOutput($sformatf("%s bad tx samples", name), badBits, 0);
      checkOutput($sformatf("%s busy-low samples", name), badBusy, 0);
      checkOutput($sformatf("%s end {tx,busy}", name), {30'd0, getTx(w), getBusy(w)},
                  backToBack ? 32'd1 : 32'd2);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vec_t vecs[7];
      int   p0;
      int   waited;

      vecs[0] = '{lo: 4'h5, hi: 4'hA, expByte: 8'hA5};
      vecs[1] = '{lo: 4'hF, hi: 4'h0, expByte: 8'h0F};
      vecs[2] = '{lo: 4'h0, hi: 4'hF, expByte: 8'hF0};
      vecs[3] = '{lo: 4'h3, hi: 4'hC, expByte: 8'hC3};
      vecs[4] = '{lo: 4'hE, hi: 4'h9, expByte: 8'h9E};
      vecs[5] = '{lo: 4'h0, hi: 4'h0, expByte: 8'h00};
      vecs[6] = '{lo: 4'hF, hi: 4'hF, expByte: 8'hFF};

      rst_n = 1'b0;
      en    = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset tx", tx, 1);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset rinc", fifo_if.rinc, 0);
      checkOutput("reset half_pending", half_pending, 0);
      checkOutput("reset tx2", tx2, 1);
      checkOutput("reset half_pending2", half_pending2, 0);
      rst_n = 1'b1;
      en    = 1'b1;
      @(negedge clk);

      $display("[TB] table-driven byte frames");
      for (int i = 0; i < 7; i++) begin
         p0 = popCount;
         applyStimulus(0, vecs[i].lo);
         applyStimulus(0, vecs[i].hi);
         checkFrame(0, vecs[i].expByte, 1'b0, $sformatf("vec%0d", i));
         checkOutput($sformatf("vec%0d pops", i), popCount - p0, 2);
      end

      $display("[TB] four nibbles, back-to-back frames");
      p0 = popCount;
      applyStimulus(0, 4'h1);
      applyStimulus(0, 4'h2);
      applyStimulus(0, 4'h3);
      applyStimulus(0, 4'h4);
      checkFrame(0, 8'h21, 1'b1, "b2b first");
      checkOutput("pops before first frame", frameStartPops - p0, 2);
      checkOutput("pops by end of first frame", popCount - p0, 4);
      checkFrame(0, 8'h43, 1'b0, "b2b second");

      $display("[TB] single nibble waits for its partner");
      applyStimulus(0, 4'h7);
      repeat (10) @(negedge clk);
      checkOutput("lone nibble half_pending", half_pending, 1);
      checkOutput("lone nibble tx", tx, 1);
      checkOutput("lone nibble busy", busy, 0);
      applyStimulus(0, 4'hC);
      checkFrame(0, 8'hC7, 1'b0, "late partner");

      $display("[TB] en=0 blocks pops and keeps half_pending");
      applyStimulus(0, 4'h3);
      repeat (6) @(negedge clk);
      en = 1'b0;
      applyStimulus(0, 4'hB);
      p0 = popCount;
      repeat (30) @(negedge clk);
      checkOutput("en=0 pops", popCount - p0, 0);
      checkOutput("en=0 half_pending", half_pending, 1);
      checkOutput("en=0 busy", busy, 0);
      checkOutput("en=0 tx", tx, 1);
      en = 1'b1;
      checkFrame(0, 8'hB3, 1'b0, "en restored");

      $display("[TB] en dropped mid-frame");
      applyStimulus(0, 4'hD);
      applyStimulus(0, 4'hE);
      fork
         checkFrame(0, 8'hED, 1'b0, "en drop");
         begin
            repeat (15) @(negedge clk);
            en = 1'b0;
         end
      join
      en = 1'b1;
      @(negedge clk);

      $display("[TB] asynchronous reset mid data bit");
      p0 = popCount;
      for (int n = 1; n <= 6; n++) applyStimulus(0, 4'(n));
      waited = 0;
      while (tx !== 1'b0 && waited < LIMIT) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("pre-reset frame start", (waited < LIMIT) ? 32'd1 : 32'd0, 32'd1);
      repeat (2 * CPB + 1) @(negedge clk);
      checkOutput("pre-reset busy", busy, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("mid-frame reset tx", tx, 1);
      checkOutput("mid-frame reset busy", busy, 0);
      checkOutput("mid-frame reset rinc", fifo_if.rinc, 0);
      checkOutput("mid-frame reset half_pending", half_pending, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      checkFrame(0, 8'h65, 1'b0, "after reset");
      checkOutput("after reset total pops", popCount - p0, 6);

      $display("[TB] RD_LAT=2 capture timing");
      applyStimulus(1, 4'h6);
      applyStimulus(1, 4'h9);
      checkFrame(1, 8'h96, 1'b0, "rdlat2");

      checkOutput("rinc single-cycle pulses", rincDbl, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
